// File: rtl/jogo_pkg.sv
`default_nettype none
// ============================================================================
// Package     : jogo_pkg
// Description : Shared constants and types for the memory-game circuit.
//               Holds the conditioning FSM state codes and the default
//               debounce window used by every button-conditioning block.
// Revision    : 1.0 - initial release
// ============================================================================
package jogo_pkg;

  // 1 ms at a 50 MHz system clock
  localparam int DEBOUNCE_CYCLES_PADRAO = 50000;

  // Play-conditioning FSM; codes 2 and 3 are unused and recover to ESPERA
  typedef enum logic [1:0] {
    ESPERA      = 2'd0,
    PRESSIONADO = 2'd1
  } estado_t;

endpackage : jogo_pkg
`default_nettype wire

// File: rtl/sincronizador_debounce.sv
`default_nettype none
// ============================================================================
// Module      : sincronizador_debounce
// Description : Two-flop synchronizer followed by a vector-wide debouncer.
//               The debounced vector only takes the synchronized value after
//               it has differed from the current debounced value for JANELA
//               consecutive clocks; any return to equality restarts the window.
// Ports       : clock   - system clock
//               reset   - asynchronous, active-low reset
//               entrada - raw asynchronous levels
//               estavel - registered debounced vector
// Revision    : 1.0 - initial release
// ============================================================================
module sincronizador_debounce
  import jogo_pkg::*;
#(
  parameter int LARGURA = 4,
  parameter int JANELA  = DEBOUNCE_CYCLES_PADRAO
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [LARGURA-1:0] entrada,
  output logic [LARGURA-1:0] estavel
);

  localparam int               CNT_W   = (JANELA > 1) ? $clog2(JANELA) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(JANELA - 1);

  logic [LARGURA-1:0] sinc1_q;
  logic [LARGURA-1:0] sinc2_q;
  logic [LARGURA-1:0] estavel_q;
  logic [LARGURA-1:0] estavel_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;

  // The counter measures how long sinc2 has disagreed with the debounced
  // value; it does not care whether the disagreeing value itself changes.
  always_comb begin
    estavel_d = estavel_q;
    cnt_d     = '0;
    if (sinc2_q != estavel_q) begin
      if (cnt_q == CNT_MAX) begin
        estavel_d = sinc2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sinc1_q   <= '0;
      sinc2_q   <= '0;
      estavel_q <= '0;
      cnt_q     <= '0;
    end else begin
      sinc1_q   <= entrada;
      sinc2_q   <= sinc1_q;
      estavel_q <= estavel_d;
      cnt_q     <= cnt_d;
    end
  end

  assign estavel = estavel_q;

endmodule : sincronizador_debounce
`default_nettype wire

// File: rtl/condicionador_jogada.sv
`default_nettype none
// ============================================================================
// Module      : condicionador_jogada
// Description : Turns raw push-button levels into play events. The debounced
//               vector is watched by a two-state FSM that emits exactly one
//               event per press: a one-hot code with a one-cycle jogada_feita
//               strobe, or a one-cycle jogada_invalida strobe for multi-key
//               presses. A new event needs the vector to return to zero.
// Ports       : clock              - system clock
//               reset              - asynchronous, active-low reset
//               chaves             - raw button levels, 1 = pressed
//               jogada             - last valid one-hot play (held)
//               jogada_feita       - strobe, same cycle jogada updates
//               jogada_invalida    - strobe for a non-one-hot press
//               db_chaves_estaveis - debounced vector (debug)
//               db_estado          - FSM state code (debug)
// Revision    : 1.0 - initial release
// ============================================================================
module condicionador_jogada
  import jogo_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_PADRAO,
  parameter int N_CHAVES        = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_CHAVES-1:0] chaves,
  output logic [N_CHAVES-1:0] jogada,
  output logic                jogada_feita,
  output logic                jogada_invalida,
  output logic [N_CHAVES-1:0] db_chaves_estaveis,
  output logic [1:0]          db_estado
);

  logic [N_CHAVES-1:0] estavel;
  logic                one_hot;

  estado_t             estado_q;
  estado_t             estado_d;
  logic [N_CHAVES-1:0] jogada_q;
  logic [N_CHAVES-1:0] jogada_d;
  logic                feita_q;
  logic                feita_d;
  logic                invalida_q;
  logic                invalida_d;

  sincronizador_debounce #(
    .LARGURA (N_CHAVES),
    .JANELA  (DEBOUNCE_CYCLES)
  ) u_sincronizador_debounce (
    .clock   (clock),
    .reset   (reset),
    .entrada (chaves),
    .estavel (estavel)
  );

  // Clearing the lowest set bit leaves zero only for a single-bit vector;
  // the zero vector is excluded separately by the FSM.
  assign one_hot = ((estavel & (estavel - 1'b1)) == '0);

  always_comb begin
    estado_d   = estado_q;
    jogada_d   = jogada_q;
    feita_d    = 1'b0;
    invalida_d = 1'b0;
    case (estado_q)
      ESPERA: begin
        if (estavel != '0) begin
          estado_d = PRESSIONADO;
          if (one_hot) begin
            jogada_d = estavel;
            feita_d  = 1'b1;
          end else begin
            invalida_d = 1'b1;
          end
        end
      end
      PRESSIONADO: begin
        // Keys added or removed while held are ignored until full release
        if (estavel == '0) begin
          estado_d = ESPERA;
        end
      end
      default: begin
        estado_d = ESPERA;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q   <= ESPERA;
      jogada_q   <= '0;
      feita_q    <= 1'b0;
      invalida_q <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      jogada_q   <= jogada_d;
      feita_q    <= feita_d;
      invalida_q <= invalida_d;
    end
  end

  assign jogada             = jogada_q;
  assign jogada_feita       = feita_q;
  assign jogada_invalida    = invalida_q;
  assign db_chaves_estaveis = estavel;
  assign db_estado          = estado_q;

endmodule : condicionador_jogada
`default_nettype wire

// File: tb/tb_condicionador_jogada.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_condicionador_jogada
// Description : Self-checking bench for condicionador_jogada with a short
//               debounce window. A reference model derives the debounced
//               vector from run lengths of the delayed raw input and queues
//               the expected play events; a monitor compares them with the
//               strobes the design presents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_condicionador_jogada;

  localparam int D = 4;

  typedef struct {
    int        ciclo;
    bit        invalida;
    logic [3:0] codigo;
  } evento_t;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] chaves = 4'h0;
  logic [3:0] jogada;
  logic       jogada_feita;
  logic       jogada_invalida;
  logic [3:0] db_chaves_estaveis;
  logic [1:0] db_estado;

  int n_cmp = 0;
  int n_bad = 0;

  condicionador_jogada #(
    .DEBOUNCE_CYCLES (D),
    .N_CHAVES        (4)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .chaves             (chaves),
    .jogada             (jogada),
    .jogada_feita       (jogada_feita),
    .jogada_invalida    (jogada_invalida),
    .db_chaves_estaveis (db_chaves_estaveis),
    .db_estado          (db_estado)
  );

  always #5 clock = ~clock;

  task automatic check(input string nome, input bit ok,
                       input logic [31:0] atual, input logic [31:0] req);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nome, atual, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Raw value seen by the debouncer at an edge is the raw value two edges
  // earlier. The stable vector adopts that value after D consecutive edges
  // of disagreement. An event is due at the edge after the stable vector
  // becomes non-zero, provided the previous press was fully released.
  evento_t    esperados[$];
  logic [3:0] hist[$];
  logic [3:0] visto;
  logic [3:0] m_estavel;
  logic [3:0] m_jogada;
  int         m_run;
  bit         m_armado;
  int         ciclo = 0;
  evento_t    ev_m;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      hist      = '{4'h0, 4'h0};
      m_estavel = 4'h0;
      m_jogada  = 4'h0;
      m_run     = 0;
      m_armado  = 1'b1;
      esperados.delete();
    end else begin
      ciclo++;
      visto = hist.pop_front();
      hist.push_back(chaves);
      if (m_armado && m_estavel != 4'h0) begin
        ev_m.ciclo    = ciclo;
        ev_m.invalida = ($countones(m_estavel) != 1);
        ev_m.codigo   = m_estavel;
        esperados.push_back(ev_m);
        if (!ev_m.invalida) m_jogada = m_estavel;
        m_armado = 1'b0;
      end else if (!m_armado && m_estavel == 4'h0) begin
        m_armado = 1'b1;
      end
      if (visto != m_estavel) begin
        m_run++;
        if (m_run == D) begin
          m_estavel = visto;
          m_run     = 0;
        end
      end else begin
        m_run = 0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  evento_t ev_c;

  always @(negedge clock) begin
    if (!reset) begin
      check("reset_outputs",
            {jogada, jogada_feita, jogada_invalida, db_chaves_estaveis, db_estado} == 16'h0,
            {jogada, jogada_feita, jogada_invalida, db_chaves_estaveis, db_estado}, 0);
    end else begin
      check("debounced", db_chaves_estaveis == m_estavel, db_chaves_estaveis, m_estavel);
      check("jogada_held", jogada == m_jogada, jogada, m_jogada);
      while (esperados.size() > 0 && esperados[0].ciclo < ciclo) begin
        ev_c = esperados.pop_front();
        check("missed_event", 1'b0, 0, ev_c.codigo);
      end
      if (jogada_feita || jogada_invalida) begin
        if (esperados.size() == 0) begin
          check("unexpected_strobe", 1'b0, {jogada_feita, jogada_invalida}, 0);
        end else begin
          ev_c = esperados.pop_front();
          check("event_cycle", ev_c.ciclo == ciclo, ciclo, ev_c.ciclo);
          check("event_kind", {jogada_feita, jogada_invalida} == {!ev_c.invalida, ev_c.invalida},
                {jogada_feita, jogada_invalida}, {!ev_c.invalida, ev_c.invalida});
          if (!ev_c.invalida)
            check("event_code", jogada == ev_c.codigo, jogada, ev_c.codigo);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic hold(input logic [3:0] v, input int n);
    chaves = v;
    repeat (n) @(negedge clock);
  endtask

  task automatic release_check(input int n);
    hold(4'h0, n);
    check("idle_state", db_estado == 2'd0, db_estado, 0);
  endtask

  task automatic pulse_reset(input int n);
    #2 reset = 1'b0;
    repeat (n) @(negedge clock);
    #2 reset = 1'b1;
  endtask

  initial begin
    int r;
    // Reset held with a key down, then released with the key still held
    chaves = 4'b0010;
    repeat (3) @(negedge clock);
    #2 reset = 1'b1;
    hold(4'b0010, 12);
    release_check(10);

    // Clean press
    hold(4'b0100, 20);
    release_check(10);

    // Bounce shorter than the window, then a steady hold
    repeat (6) begin
      hold(4'b0001, 1);
      hold(4'b0000, 1);
    end
    hold(4'b0001, 12);
    release_check(10);

    // Multi-key press
    hold(4'b1001, 10);
    release_check(10);

    // Hold-and-add, then a fresh press
    hold(4'b0001, 10);
    hold(4'b0011, 10);
    release_check(10);
    hold(4'b1000, 10);
    release_check(10);

    // Reset in the middle of a count, key kept down
    chaves = 4'b0100;
    repeat (2) @(negedge clock);
    pulse_reset(2);
    hold(4'b0100, 12);
    release_check(10);

    // Randomized presses, bounces and occasional resets
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 39);
      if (r == 0) begin
        pulse_reset($urandom_range(1, 3));
      end else begin
        case ($urandom_range(0, 3))
          0: hold(4'h0, $urandom_range(1, 12));
          1: hold(4'(1 << $urandom_range(0, 3)), $urandom_range(1, 12));
          2: hold(4'($urandom_range(0, 15)), $urandom_range(1, 12));
          default: begin
            repeat ($urandom_range(1, 4)) begin
              hold(4'($urandom_range(0, 15)), $urandom_range(1, 3));
              hold(4'h0, $urandom_range(1, 3));
            end
          end
        endcase
      end
    end

    release_check(14);
    check("queue_drained", esperados.size() == 0, esperados.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_condicionador_jogada
`default_nettype wire

// File: doc/condicionador_jogada.md
# condicionador_jogada

Input-conditioning stage for the memory-game circuit, placed directly upstream of the data path's `chaves` input and its `jogada_feita` detection. Synchronizes the four raw push-button inputs, debounces them as a vector, and turns each press into exactly one registered play event: a code plus a one-cycle strobe. Multi-key presses become a separate invalid-play strobe. The data path consumes `jogada` and `jogada_feita` in place of raw `chaves`.

## Interface

- `DEBOUNCE_CYCLES`, default 50000 — stability window in clocks (1 ms at 50 MHz); legal range ≥ 2.
- `N_CHAVES`, default 4 — number of buttons; fixed at 4 for this design, kept as a parameter for width only.

Ports:

- `clock`  in  1  — single system clock.
- `reset`  in  1  — asynchronous, active-low reset.
- `chaves`  in  N_CHAVES  — raw, asynchronous button levels; 1 = pressed.
- `jogada`  out  N_CHAVES  — registered one-hot code of the last valid play; held until the next valid play.
- `jogada_feita`  out  1  — one-cycle strobe, high in the same cycle `jogada` first shows the new code.
- `jogada_invalida`  out  1  — one-cycle strobe for a press whose debounced value is not one-hot.
- `db_chaves_estaveis`  out  N_CHAVES  — debounced vector, for debugging.
- `db_estado`  out  2  — FSM state code, for debugging.

## Operation

- **Synchronizer:** two flip-flop stages per bit, `chaves` → `sinc1` → `sinc2`.
- **Debounce, vector-wide:**
  - At each edge where `sinc2 != estavel`:
    - if `cnt == DEBOUNCE_CYCLES-1`, then `estavel <= sinc2` and `cnt <= 0`;
    - otherwise `cnt <= cnt+1`.
  - At each edge where `sinc2 == estavel`: `cnt <= 0`.
  - Any bounce restarts the window.
  - `cnt` width is `$clog2(DEBOUNCE_CYCLES)`.
- **FSM states:** ESPERA = 2'd0 and PRESSIONADO = 2'd1. Codes 2'd2 and 2'd3 are unused and recover to ESPERA.
- **ESPERA:**
  - If `estavel == 0`, stay.
  - If `estavel` is non-zero and one-hot: `jogada <= estavel`, `jogada_feita <= 1`, go to PRESSIONADO.
  - If `estavel` is non-zero and not one-hot: `jogada_invalida <= 1`, `jogada` unchanged, go to PRESSIONADO.
- **PRESSIONADO:**
  - Strobes are 0.
  - Stay while `estavel != 0`. Extra keys added or removed while held produce no event.
  - Go to ESPERA when `estavel == 0`.
- **One event per press:** a new event requires the debounced vector to return to all-zero first.
- **Outputs:** all outputs are registered, with no combinational path from `chaves`.

## Timing

- **Reset values:**
  - `sinc1`, `sinc2`, `estavel`, `cnt`, `jogada`, `jogada_feita`, `jogada_invalida` = 0.
  - `db_chaves_estaveis` = 0.
  - `db_estado` = ESPERA.
- **Press latency:** let edge 0 be the first edge sampling a new, stable raw value.
  - `sinc2` updates at edge 1.
  - `estavel` updates at edge D+1, where D = `DEBOUNCE_CYCLES`.
  - The strobe is high for exactly the one cycle following edge D+2.
- **Release latency:** `estavel` returns to 0 at edge D+1 after release. The FSM is in ESPERA after edge D+2, and a new press can be recognised from then on.
- **Glitches:** any raw pulse or bounce shorter than D clocks, as seen at `sinc2`, never changes `estavel`.
- **Reset:**
  - Reset asserted mid-press or mid-count clears everything immediately, with no strobe.
  - A key still held at reset release is debounced afresh and yields one event at edge D+2 after release.
- **Simultaneous keys:** keys pressed within the same debounce window form one vector. The result is a single `jogada_invalida` if more than one bit is set.

## Structure

- **Shared package `jogo_pkg`:**
  - state localparams ESPERA and PRESSIONADO;
  - default DEBOUNCE_CYCLES constant, also reused by any other button-conditioning block.
- **Sub-module `sincronizador_debounce`:** one natural sub-module (parameterized width and window) containing the two-flop synchronizer, counter and `estavel` register.
- **Top level `condicionador_jogada`:** holds the FSM and the event/output registers.

## Test plan

All scenarios simulate with `DEBOUNCE_CYCLES` = 4.

1. **Reset:** hold `reset`=0 with `chaves`=4'b0010 → all outputs 0 and `db_estado`=0. Release reset, keep 4'b0010 → `jogada`=4'b0010 and `jogada_feita` high for one cycle, after edge 6 following release.
2. **Clean press:** `chaves` 0→4'b0100 held 20 cycles, then 0 → exactly one `jogada_feita` pulse, 7 edges after the change. `jogada` stays 4'b0100 after release, and `db_estado` returns to 0.
3. **Bounce:** toggle `chaves` 4'b0001/0 with a 2-cycle period for 12 cycles, then hold 4'b0001 → no event during bouncing. One `jogada_feita` 7 edges after the hold starts.
4. **Multi-key:** `chaves`=4'b1001 → one `jogada_invalida` pulse, no `jogada_feita`, `jogada` unchanged from its prior value.
5. **Hold-and-add:** press 4'b0001 (event), then add 4'b0010 while held, then release all → no second event. Next press of 4'b1000 gives `jogada`=4'b1000 with one pulse.
6. **Mid-count reset:** assert `reset` 2 cycles after the press begins → no strobe. After release, the key is re-debounced and produces one event.
